// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: bus addresses, CON bit positions,
// the state type used by both serial FSMs, and the address decode helper.
package uart_pkg;

    localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
    localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
    localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

    localparam int unsigned CON_TXBUSY  = 3;
    localparam int unsigned CON_RXVALID = 4;
    localparam int unsigned CON_OVR     = 5;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    // Registers are word-aligned, so the byte offset bits never take part in the match.
    function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base);
        return (addr & 32'hFFFF_FFFC) == base;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: two-flop synchronizer, mid-bit sampling FSM and shift register.
// byte_done pulses for one cycle when a frame with a valid stop bit completes.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 10417
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
    output logic       byte_done,
    output logic [7:0] byte_data
);

    localparam logic [15:0] HALF   = 16'(BAUD_DIV / 2);
    localparam logic [15:0] RELOAD = 16'(BAUD_DIV - 1);

    logic [1:0]  sync;
    logic        rxs;
    uart_state_e state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [2:0]  bit_cnt, bit_cnt_nx;
    logic [7:0]  shreg, shreg_nx;

    assign rxs       = sync[1];
    assign byte_data = shreg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync    <= '1;
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            sync    <= {sync[0], in};
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_cnt <= bit_cnt_nx;
            shreg   <= shreg_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        byte_done  = 1'b0;
        unique case (state)
            IDLE: begin
                // Falling edge of rxs is seen one cycle early by looking at the flop feeding it.
                if (sync[1] && !sync[0]) begin
                    state_nx = START;
                    cnt_nx   = HALF;
                end
            end
            START: begin
                if (cnt == 16'd0) begin
                    if (rxs) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx   = DATA;
                        cnt_nx     = RELOAD;
                        bit_cnt_nx = '0;
                    end
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            DATA: begin
                if (cnt == 16'd0) begin
                    shreg_nx   = {rxs, shreg[7:1]};
                    cnt_nx     = RELOAD;
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nx = STOP;
                    end
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            STOP: begin
                if (cnt == 16'd0) begin
                    state_nx  = IDLE;
                    byte_done = rxs;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART slave: TXD/RXD/CON registers, transmit FSM and receive flags.
// rdata is zero unless this slave is read, so it can be OR-ed with the other slaves.
module uart_mmio
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 10417
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        in,
    output logic        out
);

    localparam logic [15:0] RELOAD = 16'(BAUD_DIV - 1);

    logic        hit_txd, hit_rxd, hit_con;
    logic        rd_rxd, rd_con;

    uart_state_e tx_state, tx_state_nx;
    logic [15:0] tx_cnt, tx_cnt_nx;
    logic [2:0]  tx_bit, tx_bit_nx;
    logic [7:0]  tx_byte, tx_byte_nx;
    logic        tx_out, tx_out_nx;
    logic        tx_busy;

    logic        rx_done;
    logic [7:0]  rx_byte;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        ovr;

    logic        unused_wdata;
    assign unused_wdata = ^wdata[31:8];

    assign hit_txd = addr_hit(addr, UART_TXD_ADDR);
    assign hit_rxd = addr_hit(addr, UART_RXD_ADDR);
    assign hit_con = addr_hit(addr, UART_CON_ADDR);
    assign rd_rxd  = rd && hit_rxd;
    assign rd_con  = rd && hit_con;
    assign tx_busy = (tx_state != IDLE);
    assign out     = tx_out;

    uart_rx_core #(
        .BAUD_DIV(BAUD_DIV)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .byte_done(rx_done),
        .byte_data(rx_byte)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_byte  <= '0;
            tx_out   <= 1'b1;
        end else begin
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_bit   <= tx_bit_nx;
            tx_byte  <= tx_byte_nx;
            tx_out   <= tx_out_nx;
        end
    end

    // The line level is registered alongside the state so the serial output never glitches.
    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt;
        tx_bit_nx   = tx_bit;
        tx_byte_nx  = tx_byte;
        tx_out_nx   = tx_out;
        unique case (tx_state)
            IDLE: begin
                tx_out_nx = 1'b1;
                if (wr && hit_txd) begin
                    tx_byte_nx  = wdata[7:0];
                    tx_state_nx = START;
                    tx_cnt_nx   = RELOAD;
                    tx_out_nx   = 1'b0;
                end
            end
            START: begin
                if (tx_cnt == 16'd0) begin
                    tx_state_nx = DATA;
                    tx_cnt_nx   = RELOAD;
                    tx_out_nx   = tx_byte[tx_bit];
                end else begin
                    tx_cnt_nx = tx_cnt - 16'd1;
                end
            end
            DATA: begin
                if (tx_cnt == 16'd0) begin
                    tx_cnt_nx = RELOAD;
                    tx_bit_nx = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) begin
                        tx_state_nx = STOP;
                        tx_out_nx   = 1'b1;
                    end else begin
                        tx_out_nx = tx_byte[tx_bit_nx];
                    end
                end else begin
                    tx_cnt_nx = tx_cnt - 16'd1;
                end
            end
            STOP: begin
                tx_out_nx = 1'b1;
                if (tx_cnt == 16'd0) begin
                    tx_state_nx = IDLE;
                end else begin
                    tx_cnt_nx = tx_cnt - 16'd1;
                end
            end
            default: tx_state_nx = IDLE;
        endcase
    end

    // A completing byte beats a same-edge RXD read (valid stays set, no overrun)
    // and a same-edge CON read (overrun set wins over clear).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            ovr      <= 1'b0;
        end else if (rx_done) begin
            rx_data  <= rx_byte;
            rx_valid <= 1'b1;
            if (rx_valid && !rd_rxd) begin
                ovr <= 1'b1;
            end else if (rd_con) begin
                ovr <= 1'b0;
            end
        end else begin
            if (rd_rxd) begin
                rx_valid <= 1'b0;
            end
            if (rd_con) begin
                ovr <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (hit_txd) begin
                rdata[7:0] = tx_byte;
            end else if (hit_rxd) begin
                rdata[7:0] = rx_data;
            end else if (hit_con) begin
                rdata[CON_TXBUSY]  = tx_busy;
                rdata[CON_RXVALID] = rx_valid;
                rdata[CON_OVR]     = ovr;
            end
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio at BAUD_DIV=4: directed scenarios plus randomized traffic,
// checked every cycle against a frame/flag level model of the UART.
module tb_uart_mmio;

    localparam int unsigned BD = 4;
    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;
    // Edges from the edge just before the start bit is driven to the edge that latches the byte.
    localparam int unsigned RX_LAT = 41;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        rd    = 1'b0;
    logic        wr    = 1'b0;
    logic        in    = 1'b1;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        out;

    uart_mmio #(.BAUD_DIV(BD)) dut (
        .clk  (clk),
        .reset(reset),
        .rd   (rd),
        .wr   (wr),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata),
        .in   (in),
        .out  (out)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned cyc       = 0;
    int unsigned m_tx_rem  = 0;
    logic [9:0]  m_frame   = '1;
    logic [7:0]  m_tx_byte = '0;
    logic [7:0]  m_rx_data = '0;
    logic        m_rx_valid = 1'b0;
    logic        m_ovr     = 1'b0;
    int unsigned pq_cyc[$];
    logic [7:0]  pq_byte[$];

    function automatic logic hit(input logic [31:0] a, input logic [31:0] base);
        return (a & 32'hFFFF_FFFC) == base;
    endfunction

    function automatic logic model_out();
        if (m_tx_rem == 0) return 1'b1;
        return m_frame[(10 * BD - m_tx_rem) / BD];
    endfunction

    function automatic logic [31:0] model_rdata();
        logic [31:0] r;
        r = '0;
        if (rd) begin
            if (hit(addr, A_TXD))      r = 32'(m_tx_byte);
            else if (hit(addr, A_RXD)) r = 32'(m_rx_data);
            else if (hit(addr, A_CON))
                r = (32'(m_ovr) << 5) | (32'(m_rx_valid) << 4) | (32'(m_tx_rem != 0) << 3);
        end
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        logic was_idle, done, rxd_rd, con_rd, set_ovr;
        if (reset) begin
            m_tx_rem   = 0;
            m_frame    = '1;
            m_tx_byte  = '0;
            m_rx_data  = '0;
            m_rx_valid = 1'b0;
            m_ovr      = 1'b0;
            pq_cyc.delete();
            pq_byte.delete();
        end else begin
            cyc++;
            was_idle = (m_tx_rem == 0);
            if (!was_idle) m_tx_rem--;
            if (wr && hit(addr, A_TXD) && was_idle) begin
                m_tx_byte = wdata[7:0];
                m_frame   = {1'b1, wdata[7:0], 1'b0};
                m_tx_rem  = 10 * BD;
            end
            done    = (pq_cyc.size() != 0) && (pq_cyc[0] == cyc);
            rxd_rd  = rd && hit(addr, A_RXD);
            con_rd  = rd && hit(addr, A_CON);
            set_ovr = done && m_rx_valid && !rxd_rd;
            if (done) begin
                m_rx_data  = pq_byte[0];
                m_rx_valid = 1'b1;
                void'(pq_cyc.pop_front());
                void'(pq_byte.pop_front());
            end else if (rxd_rd) begin
                m_rx_valid = 1'b0;
            end
            if (set_ovr)     m_ovr = 1'b1;
            else if (con_rd) m_ovr = 1'b0;
        end
    end

    always @(negedge clk) begin
        check("out", {31'b0, out}, {31'b0, model_out()});
        check("rdata", rdata, model_rdata());
    end

    // ---------------- stimulus helpers (entered and left at posedge+1) ----------------
    task automatic idle(input int unsigned n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wr = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        wr = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
        rd = 1'b1; addr = a;
        @(negedge clk);
        v = rdata;
        @(posedge clk); #1;
        rd = 1'b0; addr = '0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        if (stop_bit) begin
            pq_cyc.push_back(cyc + RX_LAT);
            pq_byte.push_back(b);
        end
        for (int k = 0; k < 10; k++) begin
            in = f[k];
            repeat (BD) @(posedge clk);
            #1;
        end
        in = 1'b1;
    endtask

    task automatic random_op();
        logic [31:0] v;
        idle($urandom_range(0, 5));
        case ($urandom_range(0, 9))
            0, 1: bus_write(A_TXD, $urandom);
            2, 3: bus_read(A_CON, v);
            4, 5: bus_read(A_RXD, v);
            6:    bus_read(A_TXD | 32'($urandom_range(1, 3)), v);
            7:    bus_read(32'h4000_0024, v);
            8:    bus_write(A_CON, $urandom);
            default: bus_read(32'h0000_0018, v);
        endcase
    endtask

    // ---------------- scenarios ----------------
    initial begin
        logic [31:0] v;
        logic [9:0]  txv;
        logic [7:0]  rb;
        logic        rs;

        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle(100);
        bus_read(A_CON, v);
        check("con_after_reset", v, 32'h00);

        // Transmit 0xA5; a second write mid-frame must be dropped.
        bus_write(A_TXD, 32'hA5);
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    txv[k] = out;
                    repeat (3) @(negedge clk);
                end
            end
            begin
                idle(12);
                bus_write(A_TXD, 32'h5A);
                bus_read(A_CON, v);
                check("tx_busy_mid", v, 32'h08);
                bus_read(A_TXD, v);
                check("tx_drop", v, 32'hA5);
            end
        join
        check("tx_frame", {22'b0, txv}, 32'h34A);
        @(posedge clk); #1;
        bus_read(A_CON, v);
        check("tx_busy_end", v, 32'h00);
        idle(5);

        // Asynchronous reset in the middle of a frame.
        bus_write(A_TXD, 32'h00);
        idle(10);
        rd = 1'b1; addr = A_CON;
        #2;
        check("pre_reset_out", {31'b0, out}, 32'h0);
        reset = 1'b1;
        #1;
        check("reset_out", {31'b0, out}, 32'h1);
        check("reset_con", rdata, 32'h00);
        @(posedge clk); #1;
        rd = 1'b0; addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle(100);

        // Single received byte.
        send_frame(8'h3C, 1'b1);
        idle(3);
        bus_read(A_CON, v); check("rx_con_valid", v, 32'h10);
        bus_read(A_RXD, v); check("rx_data", v, 32'h3C);
        bus_read(A_CON, v); check("rx_con_clear", v, 32'h00);

        // Overrun.
        send_frame(8'h11, 1'b1); idle(3);
        send_frame(8'h22, 1'b1); idle(3);
        bus_read(A_CON, v); check("ovr_con", v, 32'h30);
        bus_read(A_CON, v); check("ovr_cleared", v, 32'h10);
        bus_read(A_RXD, v); check("ovr_data", v, 32'h22);
        bus_read(A_CON, v); check("ovr_after_rxd", v, 32'h00);

        // RXD read on the same edge a new byte completes.
        send_frame(8'h11, 1'b1); idle(3);
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (RX_LAT - 1) @(posedge clk);
                #1;
                bus_read(A_RXD, v);
                check("sim_old_byte", v, 32'h11);
            end
        join
        idle(2);
        bus_read(A_CON, v); check("sim_con", v, 32'h10);
        bus_read(A_RXD, v); check("sim_new_byte", v, 32'h22);

        // Glitch, then a good frame followed by a framing error.
        in = 1'b0;
        @(posedge clk); #1;
        in = 1'b1;
        idle(20);
        bus_read(A_CON, v); check("glitch_con", v, 32'h00);
        send_frame(8'h5A, 1'b1); idle(3);
        send_frame(8'hC3, 1'b0); idle(3);
        bus_read(A_CON, v); check("frame_err_con", v, 32'h10);
        bus_read(A_RXD, v); check("frame_err_data", v, 32'h5A);

        // Randomized traffic with bus activity overlapping received frames.
        for (int it = 0; it < 30; it++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            fork
                send_frame(rb, rs);
                repeat (6) random_op();
            join
            idle($urandom_range(1, 6));
        end
        idle(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
